matmul_out_reader: RTL and testbench

- Drains the Matmul_top output buffer after `done` and streams the result matrix out as packed beats with a valid/ready handshake.
- It is the hardware reader for the output-buffer read port (`en_out_axi`/`addr_out_axi`/`dout_out_axi`, 1-cycle read latency) and replaces the software readout loop.
- It sits between Matmul_top and the DMA/stream sink.

---
 rtl/matmul_out_reader.sv | 219 +++++++++++++++++++++
 tb/tb_matmul_out_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_out_reader.sv
// -----------------------------------------------------------------------------
// matmul_out_reader
//
// Drains the Matmul_top output buffer after the multiply completes and streams
// the result matrix out as packed beats over a valid/ready interface.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle pulse (from Matmul_top done); begins a readout
//   busy       - high while a readout is in progress (READ, DRAIN, DONE)
//   finished   - one-cycle pulse after the final beat has been accepted
//   buf_en     - output-buffer read enable
//   buf_addr   - output-buffer read address (row*OUT_COLS + col)
//   buf_dout   - output-buffer read data, valid one cycle after buf_en
//   m_valid    - beat valid
//   m_ready    - sink ready
//   m_data     - PACK packed elements, lowest address in the LSBs
//   m_row_end  - beat holds the last element of a matrix row
//   m_last     - beat is the last beat of the matrix
//
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is raised, m_data/m_row_end/m_last stay constant and m_valid
// stays high until that transfer; m_valid never depends on m_ready.
// -----------------------------------------------------------------------------
module matmul_out_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_ROWS   = 64,
    parameter int OUT_COLS   = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       finished,
    output logic                       buf_en,
    output logic [ADDR_WIDTH-1:0]      buf_addr,
    input  logic [DATA_WIDTH-1:0]      buf_dout,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic                       m_row_end,
    output logic                       m_last
);

    localparam int N          = OUT_ROWS * OUT_COLS;
    localparam int NB         = N / PACK;           // beats per matrix
    localparam int BPR        = OUT_COLS / PACK;    // beats per row
    localparam int CW         = ADDR_WIDTH + 1;     // issue counter can reach N
    localparam int BCW        = $clog2(NB + 1);
    localparam int RCW        = $clog2(BPR + 1);
    localparam int FCW        = $clog2(PACK + 1);
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // FSM state, kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [CW-1:0]              issue_cnt;
    logic                       rd_pending;     // read issued last cycle, data arriving now
    logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
    logic [1:0]                 fifo_wr_ptr;
    logic [1:0]                 fifo_rd_ptr;
    logic [2:0]                 fifo_count;
    logic [DATA_WIDTH*PACK-1:0] pack_reg;
    logic [FCW-1:0]             fill;           // slots of pack_reg holding data
    logic [FCW-1:0]             slot;           // slot written by the current pop
    logic [BCW-1:0]             beat_cnt;
    logic [RCW-1:0]             row_beat;

    logic credit_ok;
    logic issue;
    logic last_issue;
    logic fifo_push;
    logic fifo_pop;
    logic load_out;
    logic beat_xfer;
    logic start_accept;

    // A read is only issued when the FIFO is guaranteed room for its data,
    // counting the read still in flight from the previous cycle.
    assign credit_ok    = (4'(fifo_count) + 4'(rd_pending)) < 4'(FIFO_DEPTH);
    assign issue        = (state == READ) && credit_ok;
    assign last_issue   = issue && (issue_cnt == CW'(N - 1));
    assign buf_en       = issue;
    assign buf_addr     = issue_cnt[ADDR_WIDTH-1:0];
    assign start_accept = (state == IDLE) && start;

    assign fifo_push = rd_pending;
    assign beat_xfer = m_valid && m_ready;
    // The finished pack moves to the output register when the output is
    // empty or is being handed off this very cycle.
    assign load_out  = (fill == FCW'(PACK)) && (!m_valid || m_ready);
    // Popping into slot 0 in the same cycle as load_out keeps one element
    // per clock flowing when the sink never stalls.
    assign fifo_pop  = (fifo_count != 3'd0) && ((fill != FCW'(PACK)) || load_out);
    assign slot      = load_out ? FCW'(0) : fill;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        finished   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                if (beat_xfer && m_last) state_next = DONE;
            end
            DONE: begin
                finished   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------- read issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (start_accept) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + CW'(1);
            end
        end
    end

    // ----------------------------------------------------- element FIFO
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= buf_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
            if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'b00, fifo_push} - {2'b00, fifo_pop};
        end
    end

    // ----------------------------------------------------------- packer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_reg <= '0;
            fill     <= '0;
        end else begin
            if (fifo_pop) begin
                for (int i = 0; i < PACK; i++) begin
                    if (slot == FCW'(i)) begin
                        pack_reg[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_mem[fifo_rd_ptr];
                    end
                end
                fill <= slot + FCW'(1);
            end else if (load_out) begin
                fill <= '0;
            end
        end
    end

    // ---------------------------------------------------- output beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_row_end <= 1'b0;
            m_last    <= 1'b0;
            beat_cnt  <= '0;
            row_beat  <= '0;
        end else begin
            if (start_accept) begin
                beat_cnt <= '0;
                row_beat <= '0;
            end
            if (load_out) begin
                m_valid   <= 1'b1;
                m_data    <= pack_reg;
                m_row_end <= (row_beat == RCW'(BPR - 1));
                m_last    <= (beat_cnt == BCW'(NB - 1));
                beat_cnt  <= beat_cnt + BCW'(1);
                row_beat  <= (row_beat == RCW'(BPR - 1)) ? '0 : row_beat + RCW'(1);
            end else if (beat_xfer) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_out_reader.sv
// -----------------------------------------------------------------------------
// Bench for matmul_out_reader: a 64x64 PACK=4 instance and a 4x4 PACK=1
// instance, each fed by a buffer model that returns its own address.
// -----------------------------------------------------------------------------
module tb_matmul_out_reader;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int PK = 4;
    localparam int N  = 4096;
    localparam int NB = 1024;
    localparam logic [63:0] BEAT0    = 64'h0003_0002_0001_0000;
    localparam logic [63:0] BEATLAST = 64'h0FFF_0FFE_0FFD_0FFC;

    // ------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance
    logic          start, busy, finished, buf_en, m_valid, m_ready, m_row_end, m_last;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_dout = '0;
    logic [63:0]   m_data;

    matmul_out_reader #(.DATA_WIDTH(DW), .OUT_ROWS(64), .OUT_COLS(64),
                        .ADDR_WIDTH(AW), .PACK(PK)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .finished(finished),
        .buf_en(buf_en), .buf_addr(buf_addr), .buf_dout(buf_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row_end(m_row_end), .m_last(m_last)
    );

    always @(posedge clk) if (buf_en) buf_dout <= {4'b0, buf_addr};

    // small instance
    logic        s_start, s_busy, s_finished, s_buf_en, s_m_valid, s_m_ready, s_m_row_end, s_m_last;
    logic [3:0]  s_buf_addr;
    logic [15:0] s_buf_dout = '0;
    logic [15:0] s_m_data;

    matmul_out_reader #(.DATA_WIDTH(16), .OUT_ROWS(4), .OUT_COLS(4),
                        .ADDR_WIDTH(4), .PACK(1)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .finished(s_finished),
        .buf_en(s_buf_en), .buf_addr(s_buf_addr), .buf_dout(s_buf_dout),
        .m_valid(s_m_valid), .m_ready(s_m_ready), .m_data(s_m_data),
        .m_row_end(s_m_row_end), .m_last(s_m_last)
    );

    always @(posedge clk) if (s_buf_en) s_buf_dout <= {12'b0, s_buf_addr};

    // ------------------------------------------------- scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_data[$];
    bit          got_row_end[$];
    bit          got_last[$];
    int          first_valid_k, fin_k, n_fin, stall_err, first_addr;
    int          credit_err = 0;
    bit          timed_out;

    // Credit invariant: elements held plus reads in flight never exceed 4.
    always @(negedge clk) begin
        if (!rst && (int'(dut.fifo_count) + int'(dut.rd_pending) > 4)) credit_err++;
    end

    function automatic logic [63:0] exp_beat(input int b);
        logic [63:0] v;
        for (int e = 0; e < PK; e++) v[e*16 +: 16] = 16'(PK*b + e);
        return v;
    endfunction

    task automatic fill_exp();
        exp_q.delete();
        for (int b = 0; b < NB; b++) exp_q.push_back(exp_beat(b));
    endtask

    // ------------------------------------------------- driver / collector
    // Pulses start, then each cycle drives m_ready, samples the outputs and
    // records accepted beats. k counts rising edges after the start edge.
    task automatic collect(input int ready_pct, input bit inject,
                           input int abort_after, input int budget);
        logic [63:0] prev_data;
        bit prev_row_end, prev_last, prev_stall;
        int k, post;
        got_data.delete(); got_row_end.delete(); got_last.delete();
        n_fin = 0; first_valid_k = -1; fin_k = -1; stall_err = 0;
        first_addr = -1; timed_out = 0; prev_stall = 0; post = -1;
        prev_data = '0; prev_row_end = 0; prev_last = 0;
        @(posedge clk); #1;
        start = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (1) begin
            m_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (first_addr < 0 && buf_en) first_addr = int'(buf_addr);
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (prev_stall && (!m_valid || m_data !== prev_data ||
                               m_row_end !== prev_row_end || m_last !== prev_last)) stall_err++;
            prev_stall = m_valid && !m_ready;
            prev_data = m_data; prev_row_end = m_row_end; prev_last = m_last;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_row_end.push_back(m_row_end);
                got_last.push_back(m_last);
                if (abort_after > 0 && got_data.size() == abort_after) return;
            end
            if (finished) begin
                n_fin++;
                if (fin_k < 0) fin_k = k;
                if (post < 0) post = 6;
            end
            start = inject && (k == 20 || (m_valid && m_last) || finished);
            if (post > 0) post--;
            if (post == 0) break;
            if (k >= budget) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------- tests
    task automatic test_reset();
        int bad;
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; s_start = 1'b0; s_ready_init();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", m_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
        checks++; if (buf_addr === '0) begin errors++; $display("FAIL pre_reset_addr got %0d exp nonzero", buf_addr); end
        // async reset between edges
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", busy); end
        checks++; if (finished !== 1'b0) begin errors++; $display("FAIL async_finished got %b exp 0", finished); end
        checks++; if (buf_en !== 1'b0) begin errors++; $display("FAIL async_buf_en got %b exp 0", buf_en); end
        checks++; if (buf_addr !== '0) begin errors++; $display("FAIL async_buf_addr got %0d exp 0", buf_addr); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL async_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL async_m_data got %h exp 0", m_data); end
        checks++; if (m_row_end !== 1'b0 || m_last !== 1'b0) begin
            errors++; $display("FAIL async_flags got %b%b exp 00", m_row_end, m_last);
        end
        checks++; if (s_busy !== 1'b0 || s_m_valid !== 1'b0) begin
            errors++; $display("FAIL small_reset got busy %b valid %b exp 0 0", s_busy, s_m_valid);
        end
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (busy !== 1'b0 || buf_en !== 1'b0 || m_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_hold got %0d active cycles exp 0", bad); end
    endtask

    task automatic s_ready_init();
        s_m_ready = 1'b0;
    endtask

    task automatic test_full_readout();
        logic [63:0] exp;
        int bad_d, bad_r, bad_l;
        collect(100, 0, 0, 6000);
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got %0d cycles exp finish", 6000); end
        checks++; if (got_data.size() != NB) begin errors++; $display("FAIL full_count got %0d exp %0d", got_data.size(), NB); end
        fill_exp();
        bad_d = 0; bad_r = 0; bad_l = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
            if (got_data[i] !== exp) begin
                bad_d++;
                if (bad_d < 5) $display("FAIL full_data[%0d] got %h exp %h", i, got_data[i], exp);
            end
            if (got_row_end[i] !== ((i % 16) == 15)) bad_r++;
            if (got_last[i] !== (i == NB - 1)) bad_l++;
        end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL full_data_total got %0d bad exp 0", bad_d); end
        checks++; if (bad_r != 0) begin errors++; $display("FAIL full_row_end got %0d bad exp 0", bad_r); end
        checks++; if (bad_l != 0) begin errors++; $display("FAIL full_last got %0d bad exp 0", bad_l); end
        checks++; if ((got_data.size() > 0 ? got_data[0] : 64'hx) !== BEAT0) begin
            errors++; $display("FAIL full_beat0 got %h exp %h", got_data.size() > 0 ? got_data[0] : 64'hx, BEAT0);
        end
        checks++; if ((got_data.size() == NB ? got_data[NB-1] : 64'hx) !== BEATLAST) begin
            errors++; $display("FAIL full_beat_last got %h exp %h", got_data.size() == NB ? got_data[NB-1] : 64'hx, BEATLAST);
        end
        checks++; if (n_fin != 1) begin errors++; $display("FAIL full_fin_count got %0d exp 1", n_fin); end
        checks++; if (fin_k < 0 || fin_k > N + 8) begin errors++; $display("FAIL full_fin_latency got %0d exp <= %0d", fin_k, N + 8); end
        checks++; if (first_valid_k < 0 || first_valid_k > PK + 3) begin
            errors++; $display("FAIL first_valid_latency got %0d exp <= %0d", first_valid_k, PK + 3);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_random_ready();
        logic [63:0] exp;
        int bad;
        credit_err = 0;
        collect(50, 0, 0, 20000);
        checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout got %0d cycles exp finish", 20000); end
        checks++; if (got_data.size() != NB) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_data.size(), NB); end
        fill_exp();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
            if (got_data[i] !== exp || got_row_end[i] !== ((i % 16) == 15) || got_last[i] !== (i == NB - 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_sequence got %0d bad beats exp 0", bad); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL rand_stall_stable got %0d changes exp 0", stall_err); end
        checks++; if (credit_err != 0) begin errors++; $display("FAIL rand_credit got %0d overflows exp 0", credit_err); end
        checks++; if (n_fin != 1) begin errors++; $display("FAIL rand_fin_count got %0d exp 1", n_fin); end
    endtask

    task automatic test_ignored_start();
        logic [63:0] exp;
        int bad;
        collect(100, 1, 0, 6000);
        checks++; if (got_data.size() != NB) begin errors++; $display("FAIL ign_count got %0d exp %0d", got_data.size(), NB); end
        fill_exp();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
            if (got_data[i] !== exp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ign_sequence got %0d bad beats exp 0", bad); end
        checks++; if (n_fin != 1) begin errors++; $display("FAIL ign_fin_count got %0d exp 1", n_fin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start got busy %b exp 0", busy); end
        // fresh readout
        collect(100, 0, 0, 6000);
        checks++; if (first_addr != 0) begin errors++; $display("FAIL restart_addr got %0d exp 0", first_addr); end
        fill_exp();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            exp = exp_q.size() > 0 ? exp_q.pop_front() : '1;
            if (got_data[i] !== exp) bad++;
        end
        checks++; if (bad != 0 || got_data.size() != NB) begin
            errors++; $display("FAIL restart_sequence got %0d bad of %0d exp 0 of %0d", bad, got_data.size(), NB);
        end
        checks++; if (n_fin != 1) begin errors++; $display("FAIL restart_fin_count got %0d exp 1", n_fin); end
    endtask

    task automatic test_reset_abort();
        int bad;
        collect(100, 0, 100, 6000);
        checks++; if (got_data.size() != 100) begin errors++; $display("FAIL abort_reach got %0d beats exp 100", got_data.size()); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || buf_en !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got busy %b valid %b en %b exp 0 0 0", busy, m_valid, buf_en);
        end
        checks++; if (buf_addr !== '0 || m_data !== '0) begin
            errors++; $display("FAIL abort_addr_data got %0d %h exp 0 0", buf_addr, m_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (finished !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_no_finish got %0d active cycles exp 0", bad); end
        collect(100, 0, 0, 6000);
        checks++; if ((got_data.size() > 0 ? got_data[0] : 64'hx) !== BEAT0) begin
            errors++; $display("FAIL abort_restart_beat0 got %h exp %h", got_data.size() > 0 ? got_data[0] : 64'hx, BEAT0);
        end
        checks++; if (got_data.size() != NB) begin errors++; $display("FAIL abort_restart_count got %0d exp %0d", got_data.size(), NB); end
        checks++; if (n_fin != 1) begin errors++; $display("FAIL abort_restart_fin got %0d exp 1", n_fin); end
    endtask

    task automatic test_small_config();
        int nb, nf, bad;
        nb = 0; nf = 0; bad = 0;
        @(posedge clk); #1;
        s_start = 1'b1; s_m_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (s_m_valid && s_m_ready) begin
                if (s_m_data !== 16'(nb) || s_m_row_end !== ((nb % 4) == 3) || s_m_last !== (nb == 15)) begin
                    bad++;
                    $display("FAIL small_beat[%0d] got %0d re %b last %b exp %0d re %b last %b",
                             nb, s_m_data, s_m_row_end, s_m_last, nb, (nb % 4) == 3, nb == 15);
                end
                nb++;
            end
            if (s_finished) nf++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL small_beats got %0d bad exp 0", bad); end
        checks++; if (nb != 16) begin errors++; $display("FAIL small_count got %0d exp 16", nb); end
        checks++; if (nf != 1) begin errors++; $display("FAIL small_fin_count got %0d exp 1", nf); end
    endtask

    // ------------------------------------------------- sequence + report
    initial begin
        test_reset();
        test_full_readout();
        test_random_ready();
        test_ignored_start();
        test_reset_abort();
        test_small_config();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
